nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Sequential wide-word adder that computes a multi-nibble sum one nibble per clock by driving a single instance of the existing `adder4bit` ripple-carry stage. It sits directly upstream of `adder4bit` and feeds it. Each cycle it presents one operand nibble pair and the running carry on `x3..x0`, `y3..y0` and `carryin`. It captures `s3..s0` and `carryout` back into a result register. A start/busy/done handshake frames each operation for the surrounding datapath.

## Interface
- `NIBBLES`, default 4: operand width in nibbles. Data width W = 4*NIBBLES. Legal range is 1..16.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: request a new addition. Sampled only in IDLE.
- `a` input, W bits: operand A, latched when start is accepted.
- `b` input, W bits: operand B, latched when start is accepted.
- `cin` input, 1 bit: carry into nibble 0, latched when start is accepted.
- `sum` output, W bits: result register, valid when `done`=1.
- `cout` output, 1 bit: carry out of the top nibble, valid when `done`=1.
- `ovf` output, 1 bit: two's-complement overflow of the W-bit add, valid when `done`=1.
- `busy` output, 1 bit: 1 while nibbles are being processed.
- `done` output, 1 bit: single-cycle completion pulse.

## Operation
- Internal structure:
  - One `adder4bit` instance.
  - `x3..x0` = `a_reg[4k+3:4k]`, `y3..y0` = `b_reg[4k+3:4k]`, `carryin` = `carry_reg`, where k is the nibble index.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `busy`=0, `done`=0.
  - If `start`=1: latch `a`, `b`, `cin` into `a_reg`, `b_reg`, `carry_reg`; clear k to 0; clear `sum` to 0; go to RUN.
- RUN, each cycle:
  - Write adder `s3..s0` into `sum[4k+3:4k]`.
  - Set `carry_reg` <= `carryout`.
  - If k = NIBBLES-1: set `cout` <= `carryout`, compute `ovf`, go to DONE.
  - Otherwise k <= k+1.
- DONE:
  - `done`=1 for exactly one cycle, then return to IDLE.
  - A `start` seen in DONE is ignored.
- `ovf` = (`a_reg[W-1]` == `b_reg[W-1]`) AND (final `sum[W-1]` != `a_reg[W-1]`).
  - `cin` takes part in the sum but not in the sign comparison.
- Arithmetic is modulo 2^W. Any carry beyond the top nibble appears only on `cout`.
- `start` while in RUN or DONE is ignored. It is not queued.
- Changes to `a`, `b` or `cin` after acceptance do not affect the operation in flight.
- `sum`, `cout` and `ovf` hold their values from DONE through IDLE until the next accepted start.
  - At the next accepted start, `sum` clears to 0.
  - `cout` and `ovf` stay unchanged until the next DONE.
- Reset:
  - `rst`=1 forces IDLE and clears `sum`, `cout`, `ovf`, `busy`, `done`, k and all operand registers to 0.
  - Reset takes priority over `start` and over every state, including mid-RUN. A partial result is discarded.

## Timing
- Edge E0: `start` is sampled in IDLE. `busy`=1 from E0.
- Edges E1..E(NIBBLES): nibbles 0..NIBBLES-1 are processed, one per edge.
- After E(NIBBLES): `done`=1, `busy`=0, and `sum`/`cout`/`ovf` are final.
- After E(NIBBLES+1): `done`=0, state is IDLE.
- Latency from start acceptance to `done` is NIBBLES cycles. This is 4 cycles at the default.
- Minimum start-to-start spacing is NIBBLES+2 cycles.
- `busy` and `done` are never high in the same cycle.
- During RUN, `sum` shows the partial result: lower nibbles are final and upper nibbles are 0. Consumers sample `sum` only on `done`.
- The adder path is combinational within one cycle: register, adder, register.

## Test plan
- Basic add, NIBBLES=4: a=0x1234, b=0x4321, cin=0, start for 1 cycle -> `done` 4 cycles after acceptance, sum=0x5555, cout=0, ovf=0, with `busy` high for exactly 4 cycles.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Handshake robustness:
  - Hold `start`=1 continuously with a=0x0001, b=0x0001.
  - Change `a` to 0xAAAA mid-RUN.
  - Required: the first result is sum=0x0002. Exactly one `done` pulse occurs per NIBBLES+2 cycles. The second operation uses a=0xAAAA.
- Reset mid-operation: assert `rst` for 1 cycle at the second RUN cycle of a=0x1111, b=0x2222 -> the next cycle shows busy=0, done=0, sum=0, cout=0, ovf=0. No `done` pulse follows, and a new start completes normally.
- Reset value check: `rst` held for 3 cycles after power-up -> all outputs 0. A `start` asserted together with `rst` is not accepted.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// master drives the request side, slave is the adder itself.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, cin,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder that reuses one adder4bit ripple stage, one nibble per clock.
// Also carries the adder4bit stage it drives.
module adder4bit (
    input  logic x3, x2, x1, x0,
    input  logic y3, y2, y1, y0,
    input  logic carryin,
    output logic s3, s2, s1, s0,
    output logic carryout
);
    logic c1, c2, c3;

    assign s0       = x0 ^ y0 ^ carryin;
    assign c1       = (x0 & y0) | (carryin & (x0 ^ y0));
    assign s1       = x1 ^ y1 ^ c1;
    assign c2       = (x1 & y1) | (c1 & (x1 ^ y1));
    assign s2       = x2 ^ y2 ^ c2;
    assign c3       = (x2 & y2) | (c2 & (x2 ^ y2));
    assign s3       = x3 ^ y3 ^ c3;
    assign carryout = (x3 & y3) | (c3 & (x3 ^ y3));
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [3:0]   k;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] sum_r;
    logic         carry_reg;
    logic         cout_r;
    logic         ovf_r;
    logic         busy_r;
    logic         done_r;

    logic [3:0]   a_nib;
    logic [3:0]   b_nib;
    logic [3:0]   s_nib;
    logic         nib_carry;

    assign a_nib = 4'(a_reg >> {k, 2'b00});
    assign b_nib = 4'(b_reg >> {k, 2'b00});

    adder4bit u_adder (
        .x3(a_nib[3]), .x2(a_nib[2]), .x1(a_nib[1]), .x0(a_nib[0]),
        .y3(b_nib[3]), .y2(b_nib[2]), .y1(b_nib[1]), .y0(b_nib[0]),
        .carryin(carry_reg),
        .s3(s_nib[3]), .s2(s_nib[2]), .s1(s_nib[1]), .s0(s_nib[0]),
        .carryout(nib_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_r     <= '0;
            carry_reg <= 1'b0;
            cout_r    <= 1'b0;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.cin;
                        k         <= '0;
                        sum_r     <= '0;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // sum was cleared at accept, so OR-ing drops the nibble into its empty slot
                    sum_r     <= sum_r | (W'(s_nib) << {k, 2'b00});
                    carry_reg <= nib_carry;
                    if (k == 4'(NIBBLES - 1)) begin
                        cout_r <= nib_carry;
                        ovf_r  <= (a_reg[W-1] == b_reg[W-1]) && (s_nib[3] != a_reg[W-1]);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised and directed checks of nibble_serial_adder against a plain-arithmetic model.
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction; expectations come from W-bit arithmetic on the operands.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
        logic [W:0] full;
        logic       eovf;
        int         lat;
        int         bcnt;
        full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        eovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.cin   = 1'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(NIBBLES));
        check({tag, ".busycycles"}, 64'(bcnt), 64'(NIBBLES));
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'(0));
        check({tag, ".sum"}, 64'(bus.sum), 64'(full[W-1:0]));
        check({tag, ".cout"}, 64'(bus.cout), 64'(full[W]));
        check({tag, ".ovf"}, 64'(bus.ovf), 64'(eovf));
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        int            dcnt;
        int            didx[2];
        logic [W-1:0]  dsum[2];
        int            n;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Reset for three edges, with start raised alongside reset on the last one.
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0001;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst.sum", 64'(bus.sum), 64'(0));
        check("rst.cout", 64'(bus.cout), 64'(0));
        check("rst.ovf", 64'(bus.ovf), 64'(0));
        check("rst.busy", 64'(bus.busy), 64'(0));
        check("rst.done", 64'(bus.done), 64'(0));
        @(negedge clk);
        check("rst.start_ignored", 64'(bus.busy), 64'(0));

        run_op("basic", 16'h1234, 16'h4321, 1'b0);
        run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0);
        run_op("ripple2", 16'hFFFF, 16'hFFFF, 1'b1);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0);

        // start held high: one done per NIBBLES+2 cycles, later operand change picked up.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.cin   = 1'b0;
        dcnt      = 0;
        for (int unsigned i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 1) bus.a = 16'hAAAA;
            check("hold.busy_done_excl", 64'(bus.busy & bus.done), 64'(0));
            if (bus.done) begin
                if (dcnt < 2) begin
                    didx[dcnt] = int'(i);
                    dsum[dcnt] = bus.sum;
                end
                dcnt++;
            end
        end
        bus.start = 1'b0;
        check("hold.pulses", 64'(dcnt), 64'(2));
        if (dcnt >= 2) begin
            check("hold.first_at", 64'(didx[0]), 64'(NIBBLES));
            check("hold.spacing", 64'(didx[1] - didx[0]), 64'(NIBBLES + 2));
            check("hold.sum1", 64'(dsum[0]), 64'(16'h0002));
            check("hold.sum2", 64'(dsum[1]), 64'(16'hAAAB));
        end
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold.drain", 64'(bus.done), 64'(1));
        check("hold.sum3", 64'(bus.sum), 64'(16'hAAAB));
        @(negedge clk);

        // Leave cout/ovf set so the mid-run reset has something to clear.
        run_op("ovf_again", 16'h8000, 16'h8000, 1'b0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", 64'(bus.busy), 64'(0));
        check("midrst.done", 64'(bus.done), 64'(0));
        check("midrst.sum", 64'(bus.sum), 64'(0));
        check("midrst.cout", 64'(bus.cout), 64'(0));
        check("midrst.ovf", 64'(bus.ovf), 64'(0));
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("midrst.no_done", 64'(dcnt), 64'(0));
        run_op("after_rst", 16'h1111, 16'h2222, 1'b0);

        for (int unsigned i = 0; i < 25; i++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
